// File: rtl/cipher_cfg_sequencer_pkg.sv
// Shared types and helpers for the cipher configuration sequencer.
// Holds the FSM state encoding and the configuration chain length helper.
package cipher_cfg_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_ARMED   = 3'd3,
        ST_START   = 3'd4,
        ST_WAIT_HI = 3'd5,
        ST_WAIT_LO = 3'd6,
        ST_ERROR   = 3'd7
    } seq_state_t;

    // Chain length: tx taps, tx state, rx taps, rx state.
    function automatic int cfg_bits(input int m);
        return 4 * m;
    endfunction

endpackage

// File: rtl/cipher_cfg_sequencer_cfg_shift_rotator.sv
// Rotating configuration register with a down-counting bit counter.
// 'last' marks the final bit of each full rotation.
module cfg_shift_rotator
    import cipher_cfg_sequencer_pkg::*;
#(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_vec,
    output logic         msb,
    output logic         last
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  rot_q;
    logic [CW-1:0] bit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_q <= '0;
            bit_q <= CW'(W - 1);
        end else if (load) begin
            rot_q <= load_vec;
            bit_q <= CW'(W - 1);
        end else if (shift) begin
            rot_q <= {rot_q[W-2:0], rot_q[W-1]};
            // Reload at terminal count so VERIFY gets a fresh full pass.
            bit_q <= (bit_q == '0) ? CW'(W - 1) : bit_q - CW'(1);
        end
    end

    assign msb  = rot_q[W-1];
    assign last = (bit_q == '0);

endmodule

// File: rtl/cipher_cfg_sequencer.sv
// Configuration loader and burst scheduler for the dual-XOR stream cipher.
// Shifts taps/states into the cipher chain, optionally verifies, then paces byte conversions.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | no valid configuration; waiting for load
// SHIFT      | shifting the 4M-bit vector into the chain
// VERIFY     | second rotation, comparing chain readback against drive
// ARMED      | configuration valid; waiting for run
// START      | one-cycle start_pulse to the converter
// WAIT_HI    | waiting for busy to rise, bounded by TIMEOUT
// WAIT_LO    | waiting for busy to fall, then count the byte
// ERROR      | readback mismatch or busy timeout; only load recovers
module cipher_cfg_sequencer
    import cipher_cfg_sequencer_pkg::*;
#(
    parameter int M       = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             verify_en,
    input  logic [M-1:0]     tx_taps_i,
    input  logic [M-1:0]     tx_state_i,
    input  logic [M-1:0]     rx_taps_i,
    input  logic [M-1:0]     rx_state_i,
    input  logic             run,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             cfg_i,
    input  logic             busy_i,
    output logic             cfg_en,
    output logic             cfg_o,
    output logic             start_pulse,
    output logic             armed,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] byte_cnt
);

    localparam int W  = cfg_bits(M);
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t       state_q, state_d;
    logic             ver_q, ver_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic             rot_load;
    logic             rot_shift;
    logic             rot_msb;
    logic             rot_last;
    logic             mismatch;
    logic [CNT_W-1:0] cnt_inc;

    cfg_shift_rotator #(
        .W (W)
    ) u_rot (
        .clk      (clk),
        .rst      (rst),
        .load     (rot_load),
        .shift    (rot_shift),
        .load_vec ({tx_taps_i, tx_state_i, rx_taps_i, rx_state_i}),
        .msb      (rot_msb),
        .last     (rot_last)
    );

    assign mismatch = (cfg_i != rot_msb);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ver_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ver_q   <= ver_d;
            err_q   <= err_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ver_d     = ver_q;
        err_d     = err_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        len_d     = len_q;
        tmo_d     = tmo_q;
        rot_load  = 1'b0;
        rot_shift = 1'b0;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (load) begin
                    rot_load = 1'b1;
                    ver_d    = verify_en;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_ARMED: begin
                // load has priority over run when both arrive together
                if (load) begin
                    rot_load = 1'b1;
                    ver_d    = verify_en;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end else if (run) begin
                    len_d = burst_len;
                    cnt_d = '0;
                    if (burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_SHIFT: begin
                rot_shift = 1'b1;
                if (rot_last) begin
                    state_d = ver_q ? ST_VERIFY : ST_ARMED;
                end
            end
            ST_VERIFY: begin
                rot_shift = 1'b1;
                if (mismatch) begin
                    err_d = 1'b1;
                end
                if (rot_last) begin
                    state_d = (err_q || mismatch) ? ST_ERROR : ST_ARMED;
                end
            end
            ST_START: begin
                tmo_d   = TW'(TIMEOUT - 1);
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (busy_i) begin
                    state_d = ST_WAIT_LO;
                end else if (tmo_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!busy_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        done_d  = 1'b1;
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decoded straight from state so reset removes them without waiting for a clock.
    assign cfg_en      = (state_q == ST_SHIFT) || (state_q == ST_VERIFY);
    assign cfg_o       = cfg_en & rot_msb;
    assign start_pulse = (state_q == ST_START);
    assign armed       = (state_q == ST_ARMED);
    assign done        = done_q;
    assign cfg_err     = err_q;
    assign byte_cnt    = cnt_q;

endmodule
